// File: rtl/riscboy_ppu_scanbuf_db.sv
// -----------------------------------------------------------------------------
// riscboy_ppu_scanbuf_db
//
// Double-buffered scanline buffer between the PPU (writer) and scanout
// (reader). Two line buffers are used in ping-pong order. Each buffer is FREE
// (writable), FULL (ready for scanout) or CLEAR (being filled with the
// background colour).
//
// Optional feature: define RISCBOY_SCANBUF_CLEAR_EN to build the clear engine.
// A released buffer is then filled with bg_colour at addresses 0..line_size,
// one word per cycle, before it becomes FREE again. Without the macro a
// released buffer goes straight to FREE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   line_size             index of the last pixel in a line
//   bg_colour             fill value for the clear engine
//   flush                 synchronous return of both buffers to FREE
//   wr_addr/wr_data/wr_en PPU pixel write into the current write buffer
//   wr_done               marks the current write buffer complete
//   wr_rdy                current write buffer accepts writes
//   scanout_raddr/ren     scanout read request, data one cycle later
//   scanout_rdata         scanout read data (held while ren is low)
//   scanout_buf_rdy       current read buffer is FULL and clear engine idle
//   scanout_buf_release   scanout finished with the current read buffer
//   level                 number of FULL buffers (registered)
// -----------------------------------------------------------------------------
module riscboy_ppu_scanbuf_db #(
  parameter int unsigned W_COORD_SX = 9,
  parameter int unsigned W_DATA     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_COORD_SX-1:0] line_size,
  input  logic [W_DATA-1:0]     bg_colour,
  input  logic                  flush,
  input  logic [W_COORD_SX-1:0] wr_addr,
  input  logic [W_DATA-1:0]     wr_data,
  input  logic                  wr_en,
  input  logic                  wr_done,
  output logic                  wr_rdy,
  input  logic [W_COORD_SX-1:0] scanout_raddr,
  input  logic                  scanout_ren,
  output logic [W_DATA-1:0]     scanout_rdata,
  output logic                  scanout_buf_rdy,
  input  logic                  scanout_buf_release,
  output logic [1:0]            level
);

  localparam int unsigned DEPTH = 2 ** W_COORD_SX;

  typedef enum logic [1:0] {
    BUF_FREE  = 2'd0,
    BUF_FULL  = 2'd1,
    BUF_CLEAR = 2'd2
  } buf_state_e;

  buf_state_e            state_q [2];
  buf_state_e            state_d [2];
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;
  logic [1:0]            level_q, level_d;
  logic [W_DATA-1:0]     rdata_q;
  logic [W_DATA-1:0]     mem [2][DEPTH];

  // Clear engine view used by the datapath; constant when the engine is absent.
  logic                  clr_busy;
  logic                  clr_sel;
  logic [W_COORD_SX-1:0] clr_addr;

  logic                  wr_accept;
  logic                  done_accept;
  logic                  rel_accept;

`ifdef RISCBOY_SCANBUF_CLEAR_EN
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_sel_q, clr_sel_d;
  logic [W_COORD_SX-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy_q <= 1'b0;
      clr_sel_q  <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_sel_q  <= clr_sel_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_sel  = clr_sel_q;
  assign clr_addr = clr_addr_q;
`else
  assign clr_busy = 1'b0;
  assign clr_sel  = 1'b0;
  assign clr_addr = '0;

  logic unused_line_size;
  assign unused_line_size = ^line_size;
`endif

  assign wr_rdy          = (state_q[wptr_q] == BUF_FREE);
  assign scanout_buf_rdy = (state_q[rptr_q] == BUF_FULL) && !clr_busy;

  assign wr_accept   = wr_en && wr_rdy;
  assign done_accept = wr_done && wr_rdy;
  assign rel_accept  = scanout_buf_release && scanout_buf_rdy;

  // wr_done and release can never target the same buffer: one needs FREE,
  // the other FULL. A release cannot occur while clearing (buf_rdy gates it),
  // so the clear-complete update never collides with a new clear.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
`ifdef RISCBOY_SCANBUF_CLEAR_EN
    clr_busy_d = clr_busy_q;
    clr_sel_d  = clr_sel_q;
    clr_addr_d = clr_addr_q;

    if (clr_busy_q) begin
      if (clr_addr_q == line_size) begin
        clr_busy_d         = 1'b0;
        state_d[clr_sel_q] = BUF_FREE;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
      end
    end
`endif

    if (done_accept) begin
      state_d[wptr_q] = BUF_FULL;
      wptr_d          = ~wptr_q;
    end

    if (rel_accept) begin
      rptr_d = ~rptr_q;
`ifdef RISCBOY_SCANBUF_CLEAR_EN
      state_d[rptr_q] = BUF_CLEAR;
      clr_busy_d      = 1'b1;
      clr_sel_d       = rptr_q;
      clr_addr_d      = '0;
`else
      state_d[rptr_q] = BUF_FREE;
`endif
    end

    unique case ({done_accept, rel_accept})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase

    if (flush) begin
      state_d[0] = BUF_FREE;
      state_d[1] = BUF_FREE;
      wptr_d     = 1'b0;
      rptr_d     = 1'b0;
      level_d    = '0;
`ifdef RISCBOY_SCANBUF_CLEAR_EN
      clr_busy_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= BUF_FREE;
      state_q[1] <= BUF_FREE;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      level_q    <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  // Buffer storage, not reset. The PPU only writes a FREE buffer and the
  // clear engine only writes a CLEAR buffer, so each buffer has one writer
  // per cycle.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (wr_accept && (wptr_q == 1'b0)) begin
        mem[0][wr_addr] <= wr_data;
      end else if (clr_busy && (clr_sel == 1'b0)) begin
        mem[0][clr_addr] <= bg_colour;
      end
      if (wr_accept && (wptr_q == 1'b1)) begin
        mem[1][wr_addr] <= wr_data;
      end else if (clr_busy && (clr_sel == 1'b1)) begin
        mem[1][clr_addr] <= bg_colour;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (scanout_ren) begin
      rdata_q <= mem[rptr_q][scanout_raddr];
    end
  end

  assign scanout_rdata = rdata_q;
  assign level         = level_q;

endmodule
